// File: rtl/prefetch_byte_window_if.sv
`default_nettype none
// ============================================================================
// Module      : prefetch_byte_window_if
// Description : Handshake/bus bundle between prefetch FIFO, byte window and decode
// Revision    : 1.0 - initial release
// ============================================================================
interface prefetch_byte_window_if #(
    parameter int WIN_BYTES = 16
);
    logic                                 pr_reset;
    logic                                 prefetchfifo_accept_empty;
    logic [67:0]                          prefetchfifo_accept_data;
    logic                                 prefetchfifo_accept_do;
    logic                                 dec_consume_do;
    logic [3:0]                           dec_consume_count;
    logic [WIN_BYTES*8-1:0]               window_data;
    logic [$clog2(WIN_BYTES+1)-1:0]       window_count;
    logic                                 window_fault_pf;
    logic                                 window_fault_gp;

    // Fetch/decode side drives the requests and observes the window.
    modport master (
        output pr_reset, prefetchfifo_accept_empty, prefetchfifo_accept_data,
        output dec_consume_do, dec_consume_count,
        input  prefetchfifo_accept_do, window_data, window_count,
        input  window_fault_pf, window_fault_gp
    );

    modport slave (
        input  pr_reset, prefetchfifo_accept_empty, prefetchfifo_accept_data,
        input  dec_consume_do, dec_consume_count,
        output prefetchfifo_accept_do, window_data, window_count,
        output window_fault_pf, window_fault_gp
    );
endinterface
`default_nettype wire

// File: rtl/prefetch_byte_window.sv
`default_nettype none
// ============================================================================
// Module      : prefetch_byte_window
// Description : Packs prefetch FIFO entries into a little-endian decode window
//               and latches GP/PF fault markers from the stream.
// Revision    : 1.0 - initial release
// ============================================================================
module prefetch_byte_window #(
    parameter int WIN_BYTES = 16,
    parameter int LEN_PF    = 14,
    parameter int LEN_GP    = 15
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    prefetch_byte_window_if.slave   bus
);
    localparam int          c_cw     = $clog2(WIN_BYTES + 1);
    localparam int          c_ww     = WIN_BYTES * 8;
    localparam logic [3:0]  c_len_pf = 4'(LEN_PF);
    localparam logic [3:0]  c_len_gp = 4'(LEN_GP);
    localparam logic [c_cw-1:0] c_fill_max = c_cw'(WIN_BYTES - 4);

    logic [c_ww-1:0]  r_data;
    logic [c_cw-1:0]  r_count;
    logic             r_fault_pf;
    logic             r_fault_gp;

    logic [3:0]       w_len;
    logic             w_accept;
    logic [2:0]       w_len_eff;
    logic [3:0]       w_consume;
    logic [c_cw-1:0]  w_rem;
    logic [31:0]      w_new_word;
    logic [c_ww-1:0]  w_shifted;
    logic [c_ww-1:0]  w_append;
    logic [c_ww-1:0]  w_data_nxt;
    logic [c_cw-1:0]  w_count_nxt;
    logic             w_unused_hi;

    assign w_unused_hi = ^bus.prefetchfifo_accept_data[63:32];

    always_comb begin
        w_len      = bus.prefetchfifo_accept_data[67:64];
        // Space check looks only at the registered count, never at this cycle's consume.
        w_accept   = rst_n & ~bus.prefetchfifo_accept_empty & ~bus.pr_reset
                   & ~r_fault_pf & ~r_fault_gp & (r_count <= c_fill_max);
        w_len_eff  = (w_accept && (w_len >= 4'd1) && (w_len <= 4'd4)) ? w_len[2:0] : 3'd0;
        w_consume  = bus.dec_consume_do ? bus.dec_consume_count : 4'd0;
        w_rem      = (c_cw'(w_consume) >= r_count) ? '0 : r_count - c_cw'(w_consume);
        w_new_word = '0;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < w_len_eff) begin
                w_new_word[8*i +: 8] = bus.prefetchfifo_accept_data[8*i +: 8];
            end
        end
        // Bytes above the count are always zero, so over-shifting on a protocol
        // violation still leaves an all-zero window.
        w_shifted   = r_data >> {w_consume, 3'b000};
        w_append    = {{(c_ww-32){1'b0}}, w_new_word} << {w_rem, 3'b000};
        w_data_nxt  = w_shifted | w_append;
        w_count_nxt = w_rem + c_cw'(w_len_eff);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data     <= '0;
            r_count    <= '0;
            r_fault_pf <= 1'b0;
            r_fault_gp <= 1'b0;
        end else if (bus.pr_reset) begin
            r_data     <= '0;
            r_count    <= '0;
            r_fault_pf <= 1'b0;
            r_fault_gp <= 1'b0;
        end else begin
            r_data  <= w_data_nxt;
            r_count <= w_count_nxt;
            if (w_accept && (w_len == c_len_pf)) begin
                r_fault_pf <= 1'b1;
            end
            if (w_accept && (w_len == c_len_gp)) begin
                r_fault_gp <= 1'b1;
            end
        end
    end

    assign bus.prefetchfifo_accept_do = w_accept;
    assign bus.window_data            = r_data;
    assign bus.window_count           = r_count;
    // Faults are reported only once every byte fetched before them has drained.
    assign bus.window_fault_pf        = r_fault_pf & (r_count == '0);
    assign bus.window_fault_gp        = r_fault_gp & (r_count == '0);
endmodule
`default_nettype wire

// File: tb/tb_prefetch_byte_window.sv
`default_nettype none
// ============================================================================
// Module      : tb_prefetch_byte_window
// Description : Directed + random bench with a byte-queue reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prefetch_byte_window;
    logic clk;
    logic rst_n;

    prefetch_byte_window_if #(.WIN_BYTES(16)) bus ();

    prefetch_byte_window #(
        .WIN_BYTES (16),
        .LEN_PF    (14),
        .LEN_GP    (15)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] data;
        logic [4:0]   count;
        logic         pf;
        logic         gp;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  m_win[$];
    bit          m_pf;
    bit          m_gp;
    int          checks;
    int          errors;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: drive, check accept_do, advance model, then compare
    // the registered result at the following negedge.
    task automatic drive_cycle(input bit empty, input logic [3:0] len, input logic [31:0] dat,
                               input bit cdo, input logic [3:0] ccnt, input bit prr);
        bit           exp_acc;
        int           c;
        exp_t         e;
        exp_t         got;
        bus.prefetchfifo_accept_empty = empty;
        bus.prefetchfifo_accept_data  = {len, 32'hDEAD_BEEF, dat};
        bus.dec_consume_do            = cdo;
        bus.dec_consume_count         = ccnt;
        bus.pr_reset                  = prr;
        #1;
        exp_acc = !empty && !prr && !m_pf && !m_gp && (m_win.size() <= 12);
        chk("accept_do", {127'd0, bus.prefetchfifo_accept_do}, {127'd0, exp_acc});
        if (prr) begin
            m_win.delete();
            m_pf = 0;
            m_gp = 0;
        end else begin
            c = cdo ? int'(ccnt) : 0;
            for (int k = 0; k < c; k++) begin
                if (m_win.size() > 0) void'(m_win.pop_front());
            end
            if (exp_acc) begin
                if (len >= 4'd1 && len <= 4'd4) begin
                    for (int k = 0; k < int'(len); k++) m_win.push_back(dat[8*k +: 8]);
                end
                if (len == 4'd14) m_pf = 1;
                if (len == 4'd15) m_gp = 1;
            end
        end
        e.data = '0;
        for (int k = 0; k < m_win.size(); k++) e.data[8*k +: 8] = m_win[k];
        e.count = 5'(m_win.size());
        e.pf    = m_pf && (m_win.size() == 0);
        e.gp    = m_gp && (m_win.size() == 0);
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        got = sb.pop_front();
        chk("window_count", {123'd0, bus.window_count}, {123'd0, got.count});
        chk("window_data", bus.window_data, got.data);
        chk("fault_pf", {127'd0, bus.window_fault_pf}, {127'd0, got.pf});
        chk("fault_gp", {127'd0, bus.window_fault_gp}, {127'd0, got.gp});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_pf   = 0;
        m_gp   = 0;
        rst_n  = 1'b0;
        bus.pr_reset                  = 1'b0;
        bus.prefetchfifo_accept_empty = 1'b0;
        bus.prefetchfifo_accept_data  = {4'd4, 64'h0};
        bus.dec_consume_do            = 1'b0;
        bus.dec_consume_count         = 4'd0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_accept_do", {127'd0, bus.prefetchfifo_accept_do}, 128'd0);
        chk("rst_count", {123'd0, bus.window_count}, 128'd0);
        chk("rst_data", bus.window_data, 128'd0);
        chk("rst_faults", {126'd0, bus.window_fault_pf, bus.window_fault_gp}, 128'd0);
        bus.prefetchfifo_accept_empty = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);

        // Two 4-byte pops
        drive_cycle(0, 4'd4, 32'h4433_2211, 0, 4'd0, 0);
        drive_cycle(0, 4'd4, 32'h8877_6655, 0, 4'd0, 0);
        chk("pack8_count", {123'd0, bus.window_count}, 128'd8);
        chk("pack8_data", {64'd0, bus.window_data[63:0]}, {64'd0, 64'h8877_6655_4433_2211});

        // Fill to exactly 16, then no more accepts
        drive_cycle(0, 4'd4, 32'hCCBB_AA99, 0, 4'd0, 0);
        drive_cycle(0, 4'd4, 32'h00FF_EEDD, 0, 4'd0, 0);
        chk("full_count", {123'd0, bus.window_count}, 128'd16);
        drive_cycle(0, 4'd4, 32'h1234_5678, 0, 4'd0, 0);
        chk("full_count_hold", {123'd0, bus.window_count}, 128'd16);

        // Down to 6, then consume 3 while appending 2
        drive_cycle(1, 4'd0, 32'h0, 1, 4'd10, 0);
        chk("six_count", {123'd0, bus.window_count}, 128'd6);
        drive_cycle(0, 4'd2, 32'h0000_BBAA, 1, 4'd3, 0);
        chk("mix_count", {123'd0, bus.window_count}, 128'd5);
        chk("mix_new_bytes", {112'd0, bus.window_data[39:24]}, {112'd0, 16'hBBAA});
        chk("mix_old_bytes", {104'd0, bus.window_data[23:0]}, {104'd0, 24'h00FFEE});

        // GP marker with 3 bytes pending
        drive_cycle(1, 4'd0, 32'h0, 1, 4'd2, 0);
        drive_cycle(0, 4'd15, 32'h0, 0, 4'd0, 0);
        chk("gp_hidden", {127'd0, bus.window_fault_gp}, 128'd0);
        drive_cycle(0, 4'd4, 32'h5555_5555, 0, 4'd0, 0);
        drive_cycle(0, 4'd4, 32'h5555_5555, 1, 4'd3, 0);
        chk("gp_visible", {127'd0, bus.window_fault_gp}, 128'd1);
        drive_cycle(0, 4'd4, 32'h5555_5555, 0, 4'd0, 0);

        // Flush, build count 9 with PF latched, flush with entry pending
        drive_cycle(0, 4'd4, 32'h6666_6666, 0, 4'd0, 1);
        drive_cycle(0, 4'd4, 32'h0403_0201, 0, 4'd0, 0);
        drive_cycle(0, 4'd4, 32'h0807_0605, 0, 4'd0, 0);
        drive_cycle(0, 4'd1, 32'h0000_0009, 0, 4'd0, 0);
        drive_cycle(0, 4'd14, 32'h0, 0, 4'd0, 0);
        chk("pf_count9", {123'd0, bus.window_count}, 128'd9);
        drive_cycle(0, 4'd4, 32'h7777_7777, 1, 4'd2, 1);
        chk("flush_count", {123'd0, bus.window_count}, 128'd0);
        drive_cycle(0, 4'd4, 32'h1111_2222, 0, 4'd0, 0);
        chk("resume_count", {123'd0, bus.window_count}, 128'd4);

        // Over-consume saturates; len 0 and len 9 pop without appending
        drive_cycle(1, 4'd0, 32'h0, 1, 4'd2, 0);
        drive_cycle(1, 4'd0, 32'h0, 1, 4'd5, 0);
        chk("sat_count", {123'd0, bus.window_count}, 128'd0);
        drive_cycle(0, 4'd0, 32'hAAAA_AAAA, 0, 4'd0, 0);
        drive_cycle(0, 4'd9, 32'hBBBB_BBBB, 0, 4'd0, 0);
        drive_cycle(0, 4'd3, 32'h00CC_DDEE, 0, 4'd0, 0);
        chk("len3_count", {123'd0, bus.window_count}, 128'd3);

        for (int n = 0; n < 80; n++) begin
            drive_cycle(bit'($urandom_range(0, 3) == 0),
                        4'($urandom_range(0, 15)),
                        $urandom,
                        bit'($urandom_range(0, 1)),
                        4'($urandom_range(1, 15)),
                        bit'($urandom_range(0, 9) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
